v4_peak_detector: RTL and testbench
===================================

# v4_peak_detector

Downstream consumer of the v4 trapezoidal shaping filter output. Takes one shaped sample per clock, arms on a threshold crossing, tracks the maximum of each pulse and its timestamp, and emits one amplitude event per pulse through a valid/ready handshake. Rejects retriggering with a hold-off window, flags pile-up on over-long pulses and counts events lost to back-pressure.

## Interface
- SIZE_FILTER_DATA, 16, width of shaped sample, two's-complement signed
- TS_W, 32, timestamp counter width
- MAX_WIDTH, 64, max samples above threshold before pile-up is declared (≥2)
- HOLDOFF, 16, dead-time cycles after each pulse (≥1)
- DROP_W, 16, width of dropped-event counter

- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- input_data  in  SIZE_FILTER_DATA  shaped sample, new value every clk
- threshold  in  SIZE_FILTER_DATA  signed arming level, used live
- event_valid  out  1  event register holds an unconsumed event
- event_ready  in  1  consumer accepts event at edge where valid&ready
- event_amp  out  SIZE_FILTER_DATA  peak sample value
- event_time  out  TS_W  timestamp of peak sample
- event_pileup  out  1  pulse exceeded MAX_WIDTH
- drop_count  out  DROP_W  events discarded due to full event register, saturating
- busy  out  1  state ≠ IDLE

## Operation
- ts: free-running counter, +1 every clk, wraps 2^TS_W−1 → 0. Sample taken at an edge is tagged with ts value before that edge's increment.
- All comparisons signed. x = input_data, thr = threshold.
- FSM states IDLE, RISE, WAIT_LOW, HOLDOFF:
  - IDLE: x > thr → RISE; max ← x, max_ts ← ts, width ← 1.
  - RISE: x > max → max ← x, max_ts ← ts (ties keep earliest). x ≤ thr → emit (max, max_ts, pileup=0), → HOLDOFF, hcnt ← HOLDOFF. Else width+1; if width reaches MAX_WIDTH with x > thr → emit (max, max_ts, pileup=1), → WAIT_LOW.
  - WAIT_LOW: x ≤ thr → HOLDOFF, hcnt ← HOLDOFF. No tracking, no emit.
  - HOLDOFF: hcnt−1 each clk; at edge where hcnt==1 → IDLE. Samples ignored, even if above threshold.
- Event register (one deep): emit writes amp/time/pileup and sets event_valid.
  - valid&ready at edge, no emit: valid cleared.
  - emit while register empty or being consumed at same edge: new event loaded, no drop.
  - emit while valid & !ready: new event discarded, register unchanged, drop_count+1 saturating at 2^DROP_W−1.
- Output fields stable while event_valid=1 and not consumed.
- threshold change takes effect on the next edge; never aborts a pulse in progress except via the ≤thr compare.

## Timing
- Reset values: event_valid 0, event_amp 0, event_time 0, event_pileup 0, drop_count 0, busy 0, ts 0, state IDLE.
- Latency: sample k at edge k drops to ≤thr in RISE → event_valid high after edge k (visible cycle k+1).
- Pile-up event visible the cycle after the MAX_WIDTH-th above-threshold sample.
- Minimum spacing of arming edges: pulse width + HOLDOFF + 1 cycles.
- busy goes high the cycle after the arming sample, low the cycle after HOLDOFF expires.
- Reset asserted mid-pulse or with pending event: all cleared asynchronously; no partial event emitted after release. First edge after release is ts=0.

## Test plan
- Single pulse: thr=100, samples 0,150,300,250,90 at ts 10..14, ready=1 → one event amp=300, time=12, pileup=0, valid for exactly one cycle after ts14 edge.
- Tie and hold-off: samples 200,400,400,50 then 500 within HOLDOFF=16 cycles, thr=100 → one event amp=400 with time of first 400; 500 ignored; busy low 16 cycles after the 50.
- Pile-up: MAX_WIDTH=8, thr=0, 20 samples of 1000 then 0 → one event amp=1000, pileup=1 after 8th sample; no second event on falling edge.
- Back-pressure: ready=0, three separated pulses → first event held unchanged, drop_count=2; ready=1 same edge as fourth emit → fourth event loaded, drop_count stays 2.
- Negative values: thr=−50, samples −100,−20,−60 → event amp=−20.
- Async reset in RISE and with valid=1 → outputs zero immediately; no event after release; ts restarts at 0.

Source files
------------

// File: rtl/v4_peak_detector.sv
// Pulse peak detector for the trapezoidal shaper output: arms on a threshold crossing,
// tracks each pulse's maximum and timestamp, and emits one event per pulse on a valid/ready port.
module v4_peak_detector #(
   parameter int SIZE_FILTER_DATA = 16,
   parameter int TS_W             = 32,
   parameter int MAX_WIDTH        = 64,
   parameter int HOLDOFF          = 16,
   parameter int DROP_W           = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SIZE_FILTER_DATA-1:0] input_data,
   input  logic [SIZE_FILTER_DATA-1:0] threshold,
   output logic                        event_valid,
   input  logic                        event_ready,
   output logic [SIZE_FILTER_DATA-1:0] event_amp,
   output logic [TS_W-1:0]             event_time,
   output logic                        event_pileup,
   output logic [DROP_W-1:0]           drop_count,
   output logic                        busy
);

   localparam int WCNT_W = $clog2(MAX_WIDTH + 1);
   localparam int HCNT_W = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {S_IDLE, S_RISE, S_WAIT_LOW, S_HOLDOFF} state_t;

   state_t                      state_r;
   logic [TS_W-1:0]             ts_r;
   logic [SIZE_FILTER_DATA-1:0] max_r;
   logic [TS_W-1:0]             max_ts_r;
   logic [WCNT_W-1:0]           width_r;
   logic [HCNT_W-1:0]           hcnt_r;

   logic                        above_s;
   logic                        new_max_s;
   logic                        full_width_s;
   logic [SIZE_FILTER_DATA-1:0] pk_amp_s;
   logic [TS_W-1:0]             pk_time_s;
   logic                        emit_s;
   logic [SIZE_FILTER_DATA-1:0] emit_amp_s;
   logic [TS_W-1:0]             emit_time_s;
   logic                        emit_pileup_s;

   assign busy = (state_r != S_IDLE);

   // Sample compares and the event candidate produced at this edge
   always_comb begin
      above_s       = ($signed(input_data) > $signed(threshold));
      new_max_s     = ($signed(input_data) > $signed(max_r));
      full_width_s  = (width_r == WCNT_W'(MAX_WIDTH - 1));
      pk_amp_s      = new_max_s ? input_data : max_r;
      pk_time_s     = new_max_s ? ts_r : max_ts_r;
      emit_s        = 1'b0;
      emit_amp_s    = max_r;
      emit_time_s   = max_ts_r;
      emit_pileup_s = 1'b0;
      case (state_r)
         S_RISE: begin
            if (!above_s) begin
               emit_s = 1'b1;
            end else if (full_width_s) begin
               // Pile-up event includes the current (MAX_WIDTH-th) sample in the peak search
               emit_s        = 1'b1;
               emit_amp_s    = pk_amp_s;
               emit_time_s   = pk_time_s;
               emit_pileup_s = 1'b1;
            end else begin
               emit_s = 1'b0;
            end
         end
         default: begin
            emit_s = 1'b0;
         end
      endcase
   end

   // Pulse tracking state machine and free-running timestamp
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= S_IDLE;
         ts_r     <= {TS_W{1'b0}};
         max_r    <= {SIZE_FILTER_DATA{1'b0}};
         max_ts_r <= {TS_W{1'b0}};
         width_r  <= {WCNT_W{1'b0}};
         hcnt_r   <= {HCNT_W{1'b0}};
      end else begin
         ts_r <= ts_r + TS_W'(1);
         case (state_r)
            S_IDLE: begin
               if (above_s) begin
                  state_r  <= S_RISE;
                  max_r    <= input_data;
                  max_ts_r <= ts_r;
                  width_r  <= WCNT_W'(1);
               end
            end
            S_RISE: begin
               if (!above_s) begin
                  state_r <= S_HOLDOFF;
                  hcnt_r  <= HCNT_W'(HOLDOFF);
               end else begin
                  max_r    <= pk_amp_s;
                  max_ts_r <= pk_time_s;
                  width_r  <= width_r + WCNT_W'(1);
                  if (full_width_s) begin
                     state_r <= S_WAIT_LOW;
                  end
               end
            end
            S_WAIT_LOW: begin
               if (!above_s) begin
                  state_r <= S_HOLDOFF;
                  hcnt_r  <= HCNT_W'(HOLDOFF);
               end
            end
            S_HOLDOFF: begin
               hcnt_r <= hcnt_r - HCNT_W'(1);
               if (hcnt_r == HCNT_W'(1)) begin
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // One-deep event register; a new event is dropped only when the old one is stuck
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         event_valid  <= 1'b0;
         event_amp    <= {SIZE_FILTER_DATA{1'b0}};
         event_time   <= {TS_W{1'b0}};
         event_pileup <= 1'b0;
         drop_count   <= {DROP_W{1'b0}};
      end else if (emit_s) begin
         if (!event_valid || event_ready) begin
            event_valid  <= 1'b1;
            event_amp    <= emit_amp_s;
            event_time   <= emit_time_s;
            event_pileup <= emit_pileup_s;
         end else if (drop_count != {DROP_W{1'b1}}) begin
            drop_count <= drop_count + DROP_W'(1);
         end
      end else if (event_valid && event_ready) begin
         event_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_v4_peak_detector.sv
// Directed self-checking bench for v4_peak_detector (MAX_WIDTH=8, HOLDOFF=16).
module tb_v4_peak_detector;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] input_data = 16'd0;
   logic [15:0] threshold = 16'd0;
   logic        event_ready = 1'b1;
   logic        event_valid;
   logic [15:0] event_amp;
   logic [31:0] event_time;
   logic        event_pileup;
   logic [15:0] drop_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   v4_peak_detector #(
      .SIZE_FILTER_DATA(16), .TS_W(32), .MAX_WIDTH(8), .HOLDOFF(16), .DROP_W(16)
   ) dut (
      .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
      .event_valid(event_valid), .event_ready(event_ready), .event_amp(event_amp),
      .event_time(event_time), .event_pileup(event_pileup), .drop_count(drop_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [15:0] x);
      input_data = x;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      input_data = 16'd0;
      event_ready = 1'b1;
      #12;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      threshold = 16'd0;
      input_data = 16'd500;
      #3;
      checks++;
      if ({event_valid, event_pileup, busy} !== 3'b000 || event_amp !== 16'd0 ||
          event_time !== 32'd0 || drop_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: got v=%b p=%b b=%b amp=%h t=%0d drop=%0d expected all zero",
                  event_valid, event_pileup, busy, event_amp, event_time, drop_count);
      end
      do_reset();
   endtask

   task automatic test_single_pulse;
      do_reset();
      threshold = 16'd100;
      for (int i = 0; i < 11; i++) step(16'd0);
      step(16'd150);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      step(16'd300);
      step(16'd250);
      checks++;
      if (event_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b expected 0", event_valid); end
      step(16'd90);
      checks++;
      if (event_valid !== 1'b1 || event_amp !== 16'd300 || event_time !== 32'd12 || event_pileup !== 1'b0) begin
         errors++;
         $display("FAIL single_event: got v=%b amp=%0d t=%0d p=%b expected v=1 amp=300 t=12 p=0",
                  event_valid, event_amp, event_time, event_pileup);
      end
      step(16'd0);
      checks++;
      if (event_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got valid %b expected 0", event_valid); end
   endtask

   task automatic test_tie_holdoff;
      int nev;
      do_reset();
      threshold = 16'd100;
      step(16'd0);
      step(16'd200);
      step(16'd400);
      step(16'd400);
      step(16'd50);
      checks++;
      if (event_valid !== 1'b1 || event_amp !== 16'd400 || event_time !== 32'd2) begin
         errors++;
         $display("FAIL tie_event: got v=%b amp=%0d t=%0d expected v=1 amp=400 t=2",
                  event_valid, event_amp, event_time);
      end
      nev = 0;
      step(16'd500);
      if (event_valid === 1'b1) nev++;
      for (int i = 0; i < 14; i++) begin
         step(16'd0);
         if (event_valid === 1'b1) nev++;
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL holdoff_busy_15: got %b expected 1", busy); end
      step(16'd0);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL holdoff_busy_16: got %b expected 0", busy); end
      checks++;
      if (nev !== 0) begin errors++; $display("FAIL holdoff_ignored: got %0d events expected 0", nev); end
   endtask

   task automatic test_pileup;
      int nev;
      do_reset();
      threshold = 16'd0;
      for (int i = 1; i <= 8; i++) begin
         step(16'd1000);
         if (i == 7) begin
            checks++;
            if (event_valid !== 1'b0) begin errors++; $display("FAIL pileup_early: got valid %b expected 0", event_valid); end
         end
      end
      checks++;
      if (event_valid !== 1'b1 || event_amp !== 16'd1000 || event_pileup !== 1'b1 || event_time !== 32'd0) begin
         errors++;
         $display("FAIL pileup_event: got v=%b amp=%0d p=%b t=%0d expected v=1 amp=1000 p=1 t=0",
                  event_valid, event_amp, event_pileup, event_time);
      end
      nev = 0;
      for (int i = 0; i < 12; i++) begin
         step(16'd1000);
         if (event_valid === 1'b1) nev++;
      end
      for (int i = 0; i < 17; i++) begin
         step(16'd0);
         if (event_valid === 1'b1) nev++;
      end
      checks++;
      if (nev !== 0) begin errors++; $display("FAIL pileup_no_second: got %0d event cycles expected 0", nev); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL pileup_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      threshold = 16'd100;
      event_ready = 1'b0;
      step(16'd0);
      for (int k = 0; k < 4; k++) begin
         step(16'd200 + 16'(k) * 16'd100);
         if (k == 3) event_ready = 1'b1;
         step(16'd0);
         event_ready = 1'b0;
         if (k == 2) begin
            checks++;
            if (event_valid !== 1'b1 || event_amp !== 16'd200 || event_time !== 32'd1 || drop_count !== 16'd2) begin
               errors++;
               $display("FAIL bp_held: got v=%b amp=%0d t=%0d drop=%0d expected v=1 amp=200 t=1 drop=2",
                        event_valid, event_amp, event_time, drop_count);
            end
         end
         for (int i = 0; i < 17; i++) step(16'd0);
      end
      checks++;
      if (event_valid !== 1'b1 || event_amp !== 16'd500 || event_time !== 32'd58 || drop_count !== 16'd2) begin
         errors++;
         $display("FAIL bp_fourth: got v=%b amp=%0d t=%0d drop=%0d expected v=1 amp=500 t=58 drop=2",
                  event_valid, event_amp, event_time, drop_count);
      end
   endtask

   task automatic test_negative;
      do_reset();
      threshold = -16'sd50;
      step(-16'sd100);
      step(-16'sd20);
      step(-16'sd60);
      checks++;
      if (event_valid !== 1'b1 || event_amp !== 16'hFFEC || event_time !== 32'd1) begin
         errors++;
         $display("FAIL negative_event: got v=%b amp=%h t=%0d expected v=1 amp=ffec t=1",
                  event_valid, event_amp, event_time);
      end
   endtask

   task automatic test_async_reset;
      int nev;
      do_reset();
      threshold = 16'd100;
      event_ready = 1'b0;
      step(16'd200);
      step(16'd0);
      for (int i = 0; i < 16; i++) step(16'd0);
      step(16'd300);
      checks++;
      if (event_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_setup: got v=%b busy=%b expected 1 1", event_valid, busy);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({event_valid, event_pileup, busy} !== 3'b000 || event_amp !== 16'd0 || event_time !== 32'd0) begin
         errors++;
         $display("FAIL areset_immediate: got v=%b p=%b b=%b amp=%h t=%0d expected all zero",
                  event_valid, event_pileup, busy, event_amp, event_time);
      end
      event_ready = 1'b1;
      input_data = 16'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      nev = 0;
      for (int i = 0; i < 3; i++) begin
         step(16'd0);
         if (event_valid === 1'b1 || busy === 1'b1) nev++;
      end
      checks++;
      if (nev !== 0) begin errors++; $display("FAIL areset_no_event: got %0d active cycles expected 0", nev); end
      do_reset();
      step(16'd150);
      step(16'd0);
      checks++;
      if (event_valid !== 1'b1 || event_amp !== 16'd150 || event_time !== 32'd0) begin
         errors++;
         $display("FAIL areset_ts_restart: got v=%b amp=%0d t=%0d expected v=1 amp=150 t=0",
                  event_valid, event_amp, event_time);
      end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_tie_holdoff();
      test_pileup();
      test_back_to_back();
      test_negative();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
